// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin shared-adder arbiter.
package adder_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {EMPTY, FULL} arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and response bundle between the execute-stage clients and the arbiter.
interface adder_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned IDW = id_width(N_REQ);

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0][DATA_W-1:0] req_a;
    logic [N_REQ-1:0][DATA_W-1:0] req_b;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [IDW-1:0]               rsp_id;
    logic [DATA_W-1:0]            rsp_y;
    logic [15:0]                  op_count;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, op_count
    );

endinterface

// File: rtl/adder_8.sv
// The single physical byte adder shared by all requesters; carry is dropped.
module adder_8
    import adder_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    assign y = a + b;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first valid at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDW-1:0]   rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        logic [IDW-1:0] j;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = IDW'((32'(rr_ptr) + k) % N_REQ);
            if (!gnt_any && req_valid[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = j;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder_8 among N_REQ requesters, with a
// single registered, backpressured response slot.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    adder_arbiter_if.slave  bus
);

    localparam int unsigned IDW = id_width(N_REQ);

    arb_state_t        state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    rsp_id_q;
    logic [DATA_W-1:0] rsp_y_q;
    logic [15:0]       op_count_q;

    logic [N_REQ-1:0]  gnt;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_any;
    logic [DATA_W-1:0] sum;
    logic              rsp_valid, drain, can_accept, accept;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_any   (gnt_any)
    );

    adder_8 u_add (
        .a (bus.req_a[gnt_idx]),
        .b (bus.req_b[gnt_idx]),
        .y (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Grants are gated with rst_n so nothing is offered while reset is held.
    always_comb begin
        rsp_valid     = (state_q == FULL);
        drain         = rsp_valid & bus.rsp_ready;
        can_accept    = (state_q == EMPTY) | drain;
        accept        = can_accept & gnt_any & rst_n;
        bus.req_ready = accept ? gnt : '0;
    end

    assign rr_ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_y_q    <= '0;
            rsp_id_q   <= '0;
            rr_ptr_q   <= '0;
            op_count_q <= '0;
        end else begin
            if (accept) begin
                rsp_y_q  <= sum;
                rsp_id_q <= gnt_idx;
                rr_ptr_q <= rr_ptr_d;
            end
            if (drain) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a negedge monitor keeps a reference
// model and response scoreboard, while each scenario task checks its own points.
module tb_adder_arbiter;

    localparam int N = 4;

    typedef struct {
        int         id;
        logic [7:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_arbiter_if #(.N_REQ(N)) bus ();

    adder_arbiter #(.N_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    bit         sticky = 1'b0;
    bit         m_full = 1'b0;
    int         m_ptr = 0;
    logic [15:0] m_count = '0;
    exp_t       sb[$];

    // Reference model: predicts grants, response contents and op_count each cycle.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int           g;
        int           j;
        bit           drain;
        bit           can;
        exp_t         e;
        if (mon_en && rst_n) begin
            drain   = m_full && bus.rsp_ready;
            can     = !m_full || drain;
            exp_rdy = '0;
            g       = -1;
            if (can) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && bus.req_valid[j]) g = j;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            n_cmp++;
            if (bus.req_ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL mon_req_ready: got %b want %b", bus.req_ready, exp_rdy);
            end
            n_cmp++;
            if (bus.rsp_valid !== m_full) begin
                n_bad++;
                $display("FAIL mon_rsp_valid: got %b want %b", bus.rsp_valid, m_full);
            end
            n_cmp++;
            if (bus.op_count !== m_count) begin
                n_bad++;
                $display("FAIL mon_op_count: got %0d want %0d", bus.op_count, m_count);
            end
            if (m_full) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL mon_scoreboard: response present with nothing expected");
                end else if (bus.rsp_id !== 2'(sb[0].id) || bus.rsp_y !== sb[0].y) begin
                    n_bad++;
                    $display("FAIL mon_rsp: got id %0d y %h want id %0d y %h",
                             bus.rsp_id, bus.rsp_y, sb[0].id, sb[0].y);
                end
            end
            if (drain) begin
                if (sb.size() > 0) void'(sb.pop_front());
                m_count = m_count + 16'd1;
            end
            if (g >= 0) begin
                e.id = g;
                e.y  = 8'(bus.req_a[g] + bus.req_b[g]);
                sb.push_back(e);
                m_ptr  = (g + 1) % N;
                m_full = 1'b1;
            end else if (drain) begin
                m_full = 1'b0;
            end
        end
    end

    // Advance one clock; accepted requesters drop valid unless sticky is set.
    task automatic cycle();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        if (!sticky) bus.req_valid = bus.req_valid & ~hs;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i] = 8'(i);
            bus.req_b[i] = 8'h01;
        end
        #3;
        n_cmp++;
        if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs: got ready %b valid %b want 0000 0", bus.req_ready,
                     bus.rsp_valid);
        end
        n_cmp++;
        if (bus.rsp_y !== 8'h00 || bus.rsp_id !== 2'd0 || bus.op_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_regs: got y %h id %0d cnt %0d want 00 0 0", bus.rsp_y,
                     bus.rsp_id, bus.op_count);
        end
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        bus.rsp_ready = 1'b1;
        bus.req_a[0]  = 8'h00;
        bus.req_b[0]  = 8'h01;
        bus.req_valid = 4'b0001;
        cycle();
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 8'h01 || bus.rsp_id !== 2'd0) begin
            n_bad++;
            $display("FAIL basic_rsp: got v %b y %h id %0d want 1 01 0", bus.rsp_valid,
                     bus.rsp_y, bus.rsp_id);
        end
        cycle();
        n_cmp++;
        if (bus.op_count !== 16'd1 || bus.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_drain: got cnt %0d v %b want 1 0", bus.op_count, bus.rsp_valid);
        end
    endtask

    task automatic test_second();
        bus.req_a[2]  = 8'h0A;
        bus.req_b[2]  = 8'h0B;
        bus.req_valid = 4'b0100;
        cycle();
        n_cmp++;
        if (bus.rsp_y !== 8'h15 || bus.rsp_id !== 2'd2) begin
            n_bad++;
            $display("FAIL second_rsp: got y %h id %0d want 15 2", bus.rsp_y, bus.rsp_id);
        end
        cycle();
    endtask

    task automatic test_wrap();
        bus.req_a[3]  = 8'hFF;
        bus.req_b[3]  = 8'h01;
        bus.req_valid = 4'b1000;
        cycle();
        n_cmp++;
        if (bus.rsp_y !== 8'h00 || bus.rsp_id !== 2'd3) begin
            n_bad++;
            $display("FAIL wrap_rsp: got y %h id %0d want 00 3", bus.rsp_y, bus.rsp_id);
        end
        for (int c = 0; c < 20; c++) begin
            if (bus.req_valid == '0 && !m_full) break;
            cycle();
        end
        n_cmp++;
        if (bus.req_valid != '0 || m_full) begin
            n_bad++;
            $display("FAIL wrap_idle: got valid %b full %b want 0000 0", bus.req_valid, m_full);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] want_y;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i] = 8'(i);
            bus.req_b[i] = 8'h10;
        end
        sticky        = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        for (int k = 0; k < 2 * N; k++) begin
            cycle();
            want_y = 8'h10 + 8'(k % N);
            n_cmp++;
            if (bus.rsp_id !== 2'(k % N) || bus.rsp_y !== want_y) begin
                n_bad++;
                $display("FAIL fair_%0d: got id %0d y %h want id %0d y %h", k, bus.rsp_id,
                         bus.rsp_y, k % N, want_y);
            end
        end
        sticky        = 1'b0;
        bus.req_valid = '0;
        for (int c = 0; c < 20; c++) begin
            if (!m_full) break;
            cycle();
        end
        n_cmp++;
        if (bus.op_count !== 16'd11) begin
            n_bad++;
            $display("FAIL fair_count: got %0d want 11", bus.op_count);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i] = 8'(i * 3);
            bus.req_b[i] = 8'h20 + 8'(i);
        end
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        cycle();
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_cmp++;
            if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 ||
                bus.op_count !== 16'd11) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got ready %b v %b cnt %0d want 0000 1 11", c,
                         bus.req_ready, bus.rsp_valid, bus.op_count);
            end
        end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.req_valid == '0 && !m_full) break;
            cycle();
        end
        n_cmp++;
        if (bus.req_valid != '0 || m_full || bus.op_count !== 16'd15) begin
            n_bad++;
            $display("FAIL bp_release: got valid %b full %b cnt %0d want 0000 0 15",
                     bus.req_valid, m_full, bus.op_count);
        end
    endtask

    task automatic test_reset_mid();
        bus.rsp_ready = 1'b1;
        bus.req_a[0]  = 8'h01;
        bus.req_b[0]  = 8'h02;
        bus.req_valid = 4'b0001;
        cycle();
        cycle();
        // rr_ptr now 1; accept requester 1 and stall so the pointer sits at 2.
        bus.req_a[1]  = 8'h33;
        bus.req_b[1]  = 8'h44;
        bus.req_a[2]  = 8'h05;
        bus.req_b[2]  = 8'h06;
        bus.rsp_ready = 1'b0;
        sticky        = 1'b1;
        bus.req_valid = 4'b0110;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.op_count !== 16'd0 || bus.req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL rstmid_assert: got v %b cnt %0d ready %b want 0 0 0000",
                     bus.rsp_valid, bus.op_count, bus.req_ready);
        end
        m_full  = 1'b0;
        m_ptr   = 0;
        m_count = '0;
        sb.delete();
        cycle();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL rstmid_first_grant: got %b want 0010", bus.req_ready);
        end
        bus.rsp_ready = 1'b1;
        cycle();
        n_cmp++;
        if (bus.rsp_id !== 2'd1 || bus.rsp_y !== 8'h77) begin
            n_bad++;
            $display("FAIL rstmid_rsp: got id %0d y %h want 1 77", bus.rsp_id, bus.rsp_y);
        end
        sticky        = 1'b0;
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            if (bus.req_valid == '0 && !m_full) break;
            cycle();
        end
        n_cmp++;
        if (bus.req_valid != '0 || m_full || bus.op_count !== 16'd2) begin
            n_bad++;
            $display("FAIL rstmid_idle: got valid %b full %b cnt %0d want 0000 0 2",
                     bus.req_valid, m_full, bus.op_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second();
        test_wrap();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one `adder_8` instance among `N_REQ` requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one request per cycle and returns the 8-bit sum, tagged with the requester index, through a single registered response port with backpressure. It sits between the execute-stage clients that need byte additions and the single physical adder.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(N_REQ)`: width of the requester index. Derived; not overridden.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in `[N_REQ]`: request present, one bit per requester.
- `req_a` in `[N_REQ][8]`: operand a per requester.
- `req_b` in `[N_REQ][8]`: operand b per requester.
- `req_ready` out `[N_REQ]`: one-hot grant; the transfer happens when `req_valid[i] & req_ready[i]`.
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `IDW`: index of the requester that produced `rsp_y`.
- `rsp_y` out 8: `(a + b) mod 256`.
- `op_count` out 16: number of completed responses, wraps.

## Operation
- State machine: `EMPTY` and `FULL`, tracking occupancy of the response register.
- `can_accept = (state == EMPTY) | (rsp_valid & rsp_ready)`.
- Grant rule:
  - When `can_accept` is high, `req_ready` is one-hot to the first asserted `req_valid` found by scanning upward from `rr_ptr`, wrapping modulo `N_REQ`.
  - Otherwise `req_ready` is all zero.
  - `req_ready` is combinational from `req_valid`, `rr_ptr`, state and `rsp_*`.
  - `req_valid` never depends on `req_ready`. A requester holds its valid and operands stable until accepted.
- On accept of requester g:
  - The granted operands drive `adder_8`.
  - `rsp_y <= y` and `rsp_id <= g`.
  - `rr_ptr <= (g+1) mod N_REQ`.
  - State goes to `FULL`.
- On `rsp_valid & rsp_ready` with no new accept: state goes to `EMPTY` and `op_count` increments.
- Drain and accept in the same cycle: `op_count` increments, the register reloads with the new result, and state stays `FULL`.
- If no request is accepted, `rr_ptr` holds.
- Arithmetic: 8-bit wrap, no carry output. `0xFF + 0x01 = 0x00`.
- `op_count` wraps `0xFFFF` to `0x0000`.
- Reset values:
  - State `EMPTY`, so `rsp_valid = 0`.
  - `rsp_y = 0`, `rsp_id = 0`, `rr_ptr = 0`, `op_count = 0`.
  - `req_ready` all 0 while `rst_n` is low.
- Reset mid-operation: a pending response is discarded, no handshake completes, and a held requester is re-arbitrated after release.

## Timing
- Latency: a request accepted at rising edge N gives `rsp_valid = 1` after edge N, so the result is visible in cycle N+1.
- Throughput: 1 response per cycle while `rsp_ready` stays high.
- Backpressure:
  - With `rsp_ready = 0` and state `FULL`, `rsp_valid`, `rsp_y` and `rsp_id` are held stable.
  - No grants are issued during backpressure.
- Fairness: with all requesters continuously valid, each one is granted exactly once in every `N_REQ` consecutive accepts.
- Reset deassertion:
  - Assertion is asynchronous.
  - The first grant can occur at the first rising edge after `rst_n` goes high.

## Structure
- `adder_arb_pkg`:
  - `typedef enum logic {EMPTY, FULL} arb_state_t`.
  - `localparam int DATA_W = 8`.
- Sub-module `adder_8` is instantiated once (ports `a`, `b`, `y`) and fed by a mux on the grant index.
- Sub-module `rr_pick` is a combinational round-robin priority encoder:
  - Inputs: `req_valid` and `rr_ptr`.
  - Outputs: one-hot grant and index.

## Test plan
- Basic: requester 0 sends `0x00 + 0x01` with `rsp_ready = 1` → next cycle `rsp_valid = 1`, `rsp_y = 0x01`, `rsp_id = 0`, `op_count = 1` after the drain edge.
- Second op: requester 2 sends `0x0A + 0x0B` → `rsp_y = 0x15`, `rsp_id = 2`.
- Wrap: `0xFF + 0x01` → `rsp_y = 0x00`.
- Fairness: all four requesters held valid after reset with operands `(i, 0x10)` and `rsp_ready = 1` → responses with ids 0,1,2,3,0,… and `rsp_y` values 0x10, 0x11, 0x12, 0x13, one per cycle.
- Backpressure: hold `rsp_ready = 0` for 5 cycles while requests are pending → response stable, `req_ready` all 0, `op_count` unchanged; on release, one response per cycle resumes with no loss or duplication.
- Reset mid-operation: assert `rst_n = 0` while `FULL` with `rsp_ready = 0` → immediately `rsp_valid = 0`, `op_count = 0`, `rr_ptr = 0`; after release the first grant goes to the lowest valid index.
